// File: rtl/uart_defines.sv
// uart_defines: receiver state encodings and oversampling default shared by the UART blocks
package uart_defines;
  localparam int OVS_DEFAULT = 16;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, WAIT_HIGH = 3'd4} state_t;
endpackage

// File: rtl/uart_ovs_tick.sv
// uart_ovs_tick: one-cycle oversample tick every DIV clocks; clr restarts the phase
module uart_ovs_tick #(
  parameter int DIV = 54
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == LAST;
  always_ff @(posedge sys_clk) begin
    r_cnt <= (rst || clr || tick) ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling 8N1 receiver; samples each bit mid-cell, flags bad stop bits
module uart_rx_ovs import uart_defines::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = OVS_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data_o,
  output logic       rx_bits_ok,
  output logic       rx_idle,
  output logic       frame_err
);
  localparam int DIV = (CLK_HZ + BAUD * OVS / 2) / (BAUD * OVS);
  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] OVS_MID  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);
  state_t          r_state, w_next;
  logic            r_sync1, r_rxd_s;
  logic [OW-1:0]   r_ovs;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_tick, w_clr, w_ovs_rst, w_sample, w_done, w_ferr, w_mid, w_bit_end;
  uart_ovs_tick #(.DIV(DIV)) u_tick (.sys_clk(sys_clk), .rst(rst), .clr(w_clr), .tick(w_tick));
  assign w_mid     = w_tick && r_ovs == OVS_MID;
  assign w_bit_end = w_tick && r_ovs == OVS_LAST;
  assign rx_idle   = r_state == IDLE;
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_ovs_rst = 1'b0;
    w_sample  = 1'b0;
    w_done    = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr  = !r_rxd_s;
        w_next = r_rxd_s ? IDLE : START;
      end
      START: if (w_mid) begin
        w_ovs_rst = 1'b1;
        w_next    = r_rxd_s ? IDLE : DATA;
      end
      DATA: if (w_bit_end) begin
        w_sample  = 1'b1;
        w_ovs_rst = 1'b1;
        w_next    = r_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (w_bit_end) begin
        w_done = r_rxd_s;
        w_ferr = !r_rxd_s;
        w_next = r_rxd_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: w_next = r_rxd_s ? IDLE : WAIT_HIGH;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_ovs      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      rx_data_o  <= '0;
      rx_bits_ok <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_sync1    <= rxd;
      r_rxd_s    <= r_sync1;
      r_ovs      <= (w_clr || w_ovs_rst) ? '0 : w_tick ? r_ovs + 1'b1 : r_ovs;
      r_bit      <= w_clr ? '0 : w_sample ? r_bit + 1'b1 : r_bit;
      r_shift    <= w_sample ? {r_rxd_s, r_shift[7:1]} : r_shift;
      rx_data_o  <= w_done ? r_shift : rx_data_o;
      rx_bits_ok <= w_done;
      frame_err  <= w_ferr;
    end
  end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: table-driven frames plus corner sequences, checked through an event scoreboard
module tb_uart_rx_ovs;
  // 12 MHz / (115200*16) = 6.51 -> rounds to 7 clocks per tick, 112 clocks per bit
  localparam int DIV = 7;
  localparam int BIT = 16 * DIV;
  localparam int LAT = 2 + (19 * BIT) / 2;
  typedef struct { logic err; logic [7:0] data; } ev_t;
  typedef struct { logic [7:0] data; logic stop; logic exp_err; logic [7:0] exp_data; } vec_t;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_bits_ok, rx_idle, frame_err;
  ev_t        q[$];
  vec_t       vecs[7];
  int         n_cmp = 0, n_err = 0, cyc = 0, t_edge = 0, p_cyc = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] last_data = 8'h00;

  uart_rx_ovs #(.CLK_HZ(12_000_000), .BAUD(115200), .OVS(16)) dut (
    .sys_clk(sys_clk), .rst(rst), .rxd(rxd), .rx_data_o(rx_data_o),
    .rx_bits_ok(rx_bits_ok), .rx_idle(rx_idle), .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (!rst && (rx_bits_ok || frame_err)) begin
      n_cmp++;
      if (rx_bits_ok && frame_err) begin
        n_err++;
        $display("FAIL overlap: ok=%b err=%b both high, want at most one", rx_bits_ok, frame_err);
      end else if (prev_pulse) begin
        n_err++;
        $display("FAIL pulse_width: ok=%b err=%b still high, want 1-cycle pulse", rx_bits_ok, frame_err);
      end else if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected: ok=%b err=%b data=%h, want no pulse", rx_bits_ok, frame_err, rx_data_o);
      end else begin
        ev_t e;
        e = q.pop_front();
        p_cyc = cyc;
        if (frame_err !== e.err || rx_data_o !== e.data) begin
          n_err++;
          $display("FAIL event: got err=%b data=%h, want err=%b data=%h", frame_err, rx_data_o, e.err, e.data);
        end
      end
    end
    prev_pulse = rx_bits_ok || frame_err;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    t_edge = cyc;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge sys_clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge sys_clk);
  endtask

  task automatic expect_ev(input logic err, input logic [7:0] data);
    ev_t e;
    e.err = err;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 4 * BIT) begin
      @(negedge sys_clk);
      k++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d events outstanding, want 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{8'hF0, 1'b1, 1'b0, 8'hF0};
    vecs[1] = '{8'h55, 1'b0, 1'b1, 8'hF0};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 8'h0F};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 8'hFF};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, 8'h3C};
    repeat (4) @(negedge sys_clk);
    check("rst_data", 32'(rx_data_o), 32'h00);
    check("rst_ok", 32'(rx_bits_ok), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_idle", 32'(rx_idle), 32'h1);
    rst = 1'b0;
    repeat (BIT) @(negedge sys_clk);

    for (int i = 0; i < 7; i++) begin
      expect_ev(vecs[i].exp_err, vecs[i].exp_data);
      send_byte(vecs[i].data, vecs[i].stop);
      rxd = 1'b1;
      repeat (2 * BIT) @(negedge sys_clk);
      drain("vec_drain");
      if (!vecs[i].exp_err) begin
        n_cmp++;
        if (p_cyc - t_edge < LAT - DIV - 3 || p_cyc - t_edge > LAT + DIV + 3) begin
          n_err++;
          $display("FAIL latency: got %0d cycles, want %0d +/- %0d", p_cyc - t_edge, LAT, DIV + 3);
        end
      end
    end
    last_data = 8'h3C;

    rxd = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("glitch_busy", 32'(rx_idle), 32'h0);
    repeat (10) @(negedge sys_clk);
    rxd = 1'b1;
    repeat (3 * BIT) @(negedge sys_clk);
    check("glitch_idle", 32'(rx_idle), 32'h1);
    check("glitch_data", 32'(rx_data_o), 32'(last_data));

    expect_ev(1'b0, 8'h0F);
    expect_ev(1'b0, 8'hA5);
    expect_ev(1'b0, 8'hFF);
    send_byte(8'h0F, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (BIT) @(negedge sys_clk);
    drain("b2b_drain");

    rxd = 1'b0;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rxd = i[1];
      repeat (BIT) @(negedge sys_clk);
    end
    rxd = 1'b1;
    repeat (BIT / 2) @(negedge sys_clk);
    check("mid_busy", 32'(rx_idle), 32'h0);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("mid_rst_data", 32'(rx_data_o), 32'h00);
    check("mid_rst_idle", 32'(rx_idle), 32'h1);
    check("mid_rst_ok", 32'(rx_bits_ok), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    repeat (12 * BIT) @(negedge sys_clk);
    check("mid_quiet_data", 32'(rx_data_o), 32'h00);
    expect_ev(1'b0, 8'h81);
    send_byte(8'h81, 1'b1);
    repeat (BIT) @(negedge sys_clk);
    drain("after_rst_drain");

    expect_ev(1'b1, 8'h81);
    rxd = 1'b0;
    repeat (30 * BIT) @(negedge sys_clk);
    check("break_hold", 32'(rx_idle), 32'h0);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge sys_clk);
    drain("break_drain");
    check("break_idle", 32'(rx_idle), 32'h1);
    expect_ev(1'b0, 8'hC3);
    send_byte(8'hC3, 1'b1);
    repeat (BIT) @(negedge sys_clk);
    drain("c3_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
